// File: rtl/multiplicador.sv
// multiplicador: price calculator for the scale datapath.
// Multiplies a weight in grams by a unit price in cents/kg with a
// sequential shift-add multiplier, then divides by 1000 (restoring
// division, rounded half-up) to produce the final price in cents.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle compute request, honoured only in IDLE
//   weightInGrams unsigned weight, grams (12 bits)
//   centimos      unsigned unit price, cents per kg (12 bits)
//   precotara     registered raw product weightInGrams*centimos (26 bits)
//   precof        registered rounded price in cents (19 bits)
//   busy          high while a computation is in progress
//   done          one-cycle pulse when precotara/precof are updated
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// MUL   | 12 shift-add iterations, multiplier LSB first
// ROUND | load dividend = product + 500 (half-up rounding)
// DIV   | 26 restoring-division steps by 1000, quotient MSB first
// DONE  | publish results, pulse done, return to IDLE

module multiplicador (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] weightInGrams,
    input  logic [11:0] centimos,
    output logic [25:0] precotara,
    output logic [18:0] precof,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] MUL   = 3'd1;
    localparam logic [2:0] ROUND = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [10:0] DIVISOR = 11'd1000;

    logic [2:0]  state;
    logic [4:0]  cnt;       // down-counter, step ends when it reaches 0
    logic [23:0] mcand;     // multiplicand, shifted left each MUL step
    logic [11:0] mplier;    // multiplier, shifted right each MUL step
    logic [23:0] acc;       // product accumulator, kept for precotara
    logic [25:0] dvd;       // dividend; quotient bits shift in from the right
    logic [9:0]  rem;       // partial remainder, always < 1000

    logic [10:0] rem_sh;
    logic        q_bit;
    logic [10:0] rem_sub;

    always_comb begin
        rem_sh  = {rem, dvd[25]};
        q_bit   = (rem_sh >= DIVISOR);
        rem_sub = rem_sh - DIVISOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            dvd       <= '0;
            rem       <= '0;
            precotara <= '0;
            precof    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {12'd0, weightInGrams};
                        mplier <= centimos;
                        acc    <= '0;
                        cnt    <= 5'd11;
                        busy   <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == 5'd0) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ROUND: begin
                    // Max 16769025 + 500 still fits in 26 bits.
                    dvd   <= {2'b00, acc} + 26'd500;
                    rem   <= '0;
                    cnt   <= 5'd25;
                    state <= DIV;
                end
                DIV: begin
                    // rem_sub < 1000 whenever it is kept, so 10 bits suffice.
                    rem <= q_bit ? rem_sub[9:0] : rem_sh[9:0];
                    dvd <= {dvd[24:0], q_bit};
                    if (cnt == 5'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    precotara <= {2'b00, acc};
                    precof    <= dvd[18:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador.sv
module tb_multiplicador;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] weightInGrams;
    logic [11:0] centimos;
    logic [25:0] precotara;
    logic [18:0] precof;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    multiplicador dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .weightInGrams (weightInGrams),
        .centimos      (centimos),
        .precotara     (precotara),
        .precof        (precof),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called #1 after a clock edge. Launches an operation, optionally
    // poking start during MUL (with different operands) and during the
    // DONE-state cycle. Returns #1 after the edge that raised done.
    task automatic run_op(input logic [11:0] w, input logic [11:0] c,
                          input bit glitch, output int lat);
        bit bad;
        weightInGrams = w;
        centimos      = c;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        weightInGrams = ~w;
        centimos      = c ^ 12'h5A5;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_done", {31'd0, done}, 32'd0);
        lat = 0;
        bad = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (glitch && n == 6) begin
                start         = 1'b1;
                weightInGrams = 12'd4095;
                centimos      = 12'd4095;
            end else if (glitch && n == 7) begin
                start = 1'b0;
            end else if (glitch && n == 40) begin
                start = 1'b1;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) bad = 1'b1;
        end
        start = 1'b0;
        chk("latency", lat, 32'd40);
        chk("busy_window", {31'd0, bad}, 32'd0);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [25:0] ep, input logic [18:0] ef);
        chk({tag, "_precotara"}, {6'd0, precotara}, {6'd0, ep});
        chk({tag, "_precof"}, {13'd0, precof}, {13'd0, ef});
    endtask

    initial begin
        int lat;
        int pulses;
        bit moved;
        logic [25:0] hold_p;
        logic [18:0] hold_f;

        rst_n         = 1'b0;
        start         = 1'b0;
        weightInGrams = '0;
        centimos      = '0;
        #2;
        chk("rst_precotara", {6'd0, precotara}, 32'd0);
        chk("rst_precof", {13'd0, precof}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal
        run_op(12'd1500, 12'd470, 1'b0, lat);
        check_result("nominal", 26'd705000, 19'd705);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // Rounding corners
        run_op(12'd1, 12'd500, 1'b0, lat);
        check_result("round_500", 26'd500, 19'd1);
        repeat (2) @(posedge clk); #1;
        run_op(12'd2, 12'd249, 1'b0, lat);
        check_result("round_498", 26'd498, 19'd0);
        repeat (2) @(posedge clk); #1;
        run_op(12'd3, 12'd167, 1'b0, lat);
        check_result("round_501", 26'd501, 19'd1);
        repeat (2) @(posedge clk); #1;
        run_op(12'd1000, 12'd1, 1'b0, lat);
        check_result("round_1000", 26'd1000, 19'd1);
        repeat (2) @(posedge clk); #1;

        // Extremes
        run_op(12'd4095, 12'd4095, 1'b0, lat);
        check_result("max", 26'd16769025, 19'd16769);
        repeat (2) @(posedge clk); #1;
        run_op(12'd0, 12'd4095, 1'b0, lat);
        check_result("zero_w", 26'd0, 19'd0);
        repeat (2) @(posedge clk); #1;
        run_op(12'd4095, 12'd0, 1'b0, lat);
        check_result("zero_c", 26'd0, 19'd0);
        repeat (2) @(posedge clk); #1;

        // Handshake: extra starts while busy and in the DONE-state cycle
        run_op(12'd1500, 12'd470, 1'b1, lat);
        check_result("handshake", 26'd705000, 19'd705);
        hold_p = precotara;
        hold_f = precof;
        pulses = 0;
        moved  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy) moved = 1'b1;
            if (precotara !== hold_p || precof !== hold_f) moved = 1'b1;
        end
        chk("handshake_no_extra_done", pulses, 32'd0);
        chk("handshake_stable_idle", {31'd0, moved}, 32'd0);

        // Back-to-back: second start lands in the first IDLE cycle (done cycle)
        run_op(12'd1500, 12'd470, 1'b0, lat);
        check_result("b2b_first", 26'd705000, 19'd705);
        run_op(12'd2000, 12'd999, 1'b0, lat);
        check_result("b2b_second", 26'd1998000, 19'd1998);
        repeat (2) @(posedge clk); #1;

        // Reset mid-MUL
        weightInGrams = 12'd123;
        centimos      = 12'd456;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_precotara", {6'd0, precotara}, 32'd0);
        chk("midrst_precof", {13'd0, precof}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        #3 rst_n = 1'b1;
        pulses = 0;
        moved  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (busy) moved = 1'b1;
        end
        chk("midrst_no_done", pulses, 32'd0);
        chk("midrst_idle", {31'd0, moved}, 32'd0);
        chk("midrst_hold_precotara", {6'd0, precotara}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
